// File: rtl/regf_array_pkg.sv
// Shared types and helpers for the parametrised register file array.
package regf_array_pkg;

    typedef enum logic [1:0] {
        ACC_RW = 2'd0,
        ACC_RO = 2'd1,
        ACC_RC = 2'd2
    } access_e;

    // Byte address bit where the word index starts.
    localparam int WORD_LSB = 2;
    localparam int MAX_REGS = 64;

    // Read-only wins when a word is flagged in both masks.
    function automatic access_e access_of(input int i,
                                          input logic [MAX_REGS-1:0] ro_mask,
                                          input logic [MAX_REGS-1:0] rc_mask);
        if (ro_mask[i]) return ACC_RO;
        if (rc_mask[i]) return ACC_RC;
        return ACC_RW;
    endfunction

endpackage

// File: rtl/regf_array_word.sv
// One register word: core write beats bus write, which beats read-clear.
module regf_array_word
    import regf_array_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    parameter access_e               ACCESS     = ACC_RW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_wr,
    input  logic [DATA_WIDTH-1:0] core_wval,
    input  logic                  bus_wr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rd,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  bus_wr_done
);

    logic bus_wr_ok;
    logic rd_clear;

    // A bus write only counts when the core is not writing the same word.
    assign bus_wr_ok   = bus_wr && (ACCESS != ACC_RO);
    assign bus_wr_done = bus_wr_ok && !core_wr;
    assign rd_clear    = bus_rd && (ACCESS == ACC_RC);

    // Word storage with core > bus write > read-clear priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RST_VAL;
        end else if (core_wr) begin
            value <= core_wval;
        end else if (bus_wr_ok) begin
            value <= bus_wdata;
        end else if (rd_clear) begin
            value <= '0;
        end
    end

endmodule

// File: rtl/regf_array.sv
// Parametrised register file with RW / RO / RC words on the mem bus.
// Optional macro REGF_ARRAY_RDPIPE_EN adds one output register stage to
// read data, error and read strobes (latency 2 instead of 1).
module regf_array
    import regf_array_pkg::*;
#(
    parameter int                               NUM_REGS   = 8,
    parameter int                               DATA_WIDTH = 32,
    parameter int                               ADDR_WIDTH = 13,
    parameter logic [NUM_REGS-1:0]              RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]              RC_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic                                main_clk_i,
    input  logic                                main_rst_an_i,
    input  logic                                mem_ena_i,
    input  logic [ADDR_WIDTH-1:0]               mem_addr_i,
    input  logic                                mem_wena_i,
    input  logic [DATA_WIDTH-1:0]               mem_wdata_i,
    output logic [DATA_WIDTH-1:0]               mem_rdata_o,
    output logic                                mem_err_o,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regf_rval_o,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regf_wval_i,
    input  logic [NUM_REGS-1:0]                 regf_wr_i,
    output logic [NUM_REGS-1:0]                 regf_bus_wr_o,
    output logic [NUM_REGS-1:0]                 regf_bus_rd_o
);

    localparam int IDX_W = ADDR_WIDTH - WORD_LSB;

    logic [IDX_W-1:0]      idx;
    logic [NUM_REGS-1:0]   hit;
    logic [NUM_REGS-1:0]   ro_word;
    logic [NUM_REGS-1:0]   acc_wr;
    logic [NUM_REGS-1:0]   acc_rd;
    logic [NUM_REGS-1:0]   wr_done;
    logic                  in_range;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [NUM_REGS-1:0]   bus_rd_q;

    assign idx = mem_addr_i[ADDR_WIDTH-1:WORD_LSB];

    // One-hot word select; no bit set means the index is out of range.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (int'(idx) == i);
        end
    end

    assign in_range = |hit;
    assign acc_err  = mem_ena_i && (!in_range || (mem_wena_i && |(hit & ro_word)));
    assign acc_wr   = (mem_ena_i &&  mem_wena_i && !acc_err) ? hit : '0;
    assign acc_rd   = (mem_ena_i && !mem_wena_i && !acc_err) ? hit : '0;

    // Read mux takes the pre-update value, so RC words return the pre-clear data.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hit[i]) rd_mux = regf_rval_o[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        localparam access_e ACC = access_of(g, 64'(RO_MASK), 64'(RC_MASK));

        assign ro_word[g] = (ACC == ACC_RO);

        regf_array_word #(
            .DATA_WIDTH (DATA_WIDTH),
            .RST_VAL    (RST_VAL[g*DATA_WIDTH +: DATA_WIDTH]),
            .ACCESS     (ACC)
        ) u_word (
            .clk         (main_clk_i),
            .rst_n       (main_rst_an_i),
            .core_wr     (regf_wr_i[g]),
            .core_wval   (regf_wval_i[g]),
            .bus_wr      (acc_wr[g]),
            .bus_wdata   (mem_wdata_i),
            .bus_rd      (acc_rd[g]),
            .value       (regf_rval_o[g]),
            .bus_wr_done (wr_done[g])
        );
    end

    // First response stage; write responses and idle cycles return zero data.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            rdata_q       <= '0;
            err_q         <= 1'b0;
            bus_rd_q      <= '0;
            regf_bus_wr_o <= '0;
        end else begin
            rdata_q       <= (|acc_rd) ? rd_mux : '0;
            err_q         <= acc_err;
            bus_rd_q      <= acc_rd;
            regf_bus_wr_o <= wr_done;
        end
    end

`ifdef REGF_ARRAY_RDPIPE_EN
    // Extra output stage for timing; register updates are not delayed.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            mem_rdata_o   <= '0;
            mem_err_o     <= 1'b0;
            regf_bus_rd_o <= '0;
        end else begin
            mem_rdata_o   <= rdata_q;
            mem_err_o     <= err_q;
            regf_bus_rd_o <= bus_rd_q;
        end
    end
`else
    assign mem_rdata_o   = rdata_q;
    assign mem_err_o     = err_q;
    assign regf_bus_rd_o = bus_rd_q;
`endif

endmodule

// File: doc/regf_array.md
Name: regf_array

Overview:
- Parametrised successor to the fixed-layout generated register file.
- Holds NUM_REGS words of DATA_WIDTH bits. Each word has a per-word bus access mode: RW, RO (bus read-only, core-written) or RC (bus read-clear).
- Connects to the standard mem bus (ena/addr/wena/wdata/rdata/err) on one side and per-word core strobes/values on the other.
- Adds registered read data, error signalling and bus-write notification strobes.

Parameters:
- NUM_REGS, 8, number of 32-bit-aligned words; 1..64.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 13, byte address width; word index = mem_addr_i[ADDR_WIDTH-1:2].
- RO_MASK, '0, NUM_REGS bits; bit i=1 makes word i bus read-only.
- RC_MASK, '0, NUM_REGS bits; bit i=1 makes word i bus read-clear (RW to core). RO_MASK takes precedence if both bits are set.
- RST_VAL, '0, NUM_REGS*DATA_WIDTH packed reset values; word i = RST_VAL[i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- main_clk_i  input  1  clock.
- main_rst_an_i  input  1  async reset, low-active.
- mem_ena_i  input  1  bus access request, single-cycle.
- mem_addr_i  input  ADDR_WIDTH  byte address.
- mem_wena_i  input  1  1=write, 0=read.
- mem_wdata_i  input  DATA_WIDTH  write data.
- mem_rdata_o  output  DATA_WIDTH  read data, registered.
- mem_err_o  output  1  access error, registered, aligned with rdata.
- regf_rval_o  output  [NUM_REGS][DATA_WIDTH]  current register values (core read value).
- regf_wval_i  input  [NUM_REGS][DATA_WIDTH]  core write value.
- regf_wr_i  input  NUM_REGS  core write strobe per word.
- regf_bus_wr_o  output  NUM_REGS  one-cycle pulse after a successful bus write to word i.
- regf_bus_rd_o  output  NUM_REGS  one-cycle pulse after a successful bus read of word i.

Behaviour:
- Reset:
  - regf_rval_o = RST_VAL.
  - mem_rdata_o = 0, mem_err_o = 0.
  - regf_bus_wr_o = 0, regf_bus_rd_o = 0.
  - Reset mid-access aborts the access; no response is produced after release.
- Address decode:
  - idx = mem_addr_i[ADDR_WIDTH-1:2]; mem_addr_i[1:0] are ignored.
  - Error when idx >= NUM_REGS (any access) or when writing an RO word.
- Bus write (ena=1, wena=1, no error): word updated at the next edge.
  - regf_bus_wr_o[idx] pulses in the cycle after the access.
  - mem_rdata_o = 0 in the response cycle.
- Bus read (ena=1, wena=0, no error): mem_rdata_o = word value, valid in the cycle after ena (latency 1).
  - regf_bus_rd_o[idx] pulses in the same response cycle.
  - RC word: value is cleared to 0 at the same edge that captures rdata; the bus sees the pre-clear value.
- Errored access: no register change, no strobes, mem_rdata_o = 0, mem_err_o = 1 for one cycle.
- mem_err_o and mem_rdata_o return to 0 in any cycle following an edge with ena=0.
- Core write: regf_wr_i[i]=1 loads regf_wval_i[i] at the next edge, for every mode.
- Priority (same word, same cycle):
  - Core write beats bus write: the bus write is dropped, with no error and no bus_wr strobe.
  - Core write beats RC clear: the new value is kept, but the bus still reads the old value.
- Back-to-back bus accesses every cycle are supported without stall.
- Independent core writes to all words in one cycle are allowed.

Optional Feature:
- REGF_ARRAY_RDPIPE_EN defined: one extra output register stage.
  - mem_rdata_o, mem_err_o and regf_bus_rd_o gain latency 2.
  - RC clear timing is unchanged.
  - Throughput remains one access per cycle.
- Not defined: latency 1 as above.

Decomposition:
- Package regf_array_pkg holds:
  - access_e enum (ACC_RW, ACC_RO, ACC_RC).
  - Constant for the word address LSB (2).
  - Function access_of(i, RO_MASK, RC_MASK) returning access_e.
- Sub-module regf_array_word: one word register with mode-dependent next-state logic and priority. Generated NUM_REGS times.
- The top level contains decode, error logic and response/pipeline registers.

Test Plan:
- Reset release -> regf_rval_o equals RST_VAL (e.g. word 2 = 0xA5A5_0000); first read of 0x008 returns 0xA5A5_0000 one cycle later, err=0.
- Bus write 0x1234_5678 to 0x004 (RW) -> regf_rval_o[1]=0x1234_5678 the next cycle; regf_bus_wr_o[1] pulses once; read back returns the value.
- Read of 0x020 with NUM_REGS=8 -> mem_err_o=1, rdata=0, no strobes. Write to an RO word -> err=1 and the word is unchanged.
- RC word 3 loaded 0xF by core; bus read returns 0xF and the word is 0 next cycle. If a core write of 0x7 coincides with the read: bus reads 0xF, word = 0x7.
- Same-cycle core write 0xAA and bus write 0x55 to RW word 0 -> word=0xAA, no bus_wr strobe, err=0.
- With REGF_ARRAY_RDPIPE_EN: back-to-back reads of words 0,1,2 -> rdata appears at cycles +2,+3,+4 in order. Assert reset mid-stream -> all outputs 0 and no late response.
